// File: rtl/axi_mem_master_pkg.sv
// rtl/axi_mem_master_pkg.sv - shared FSM encoding, AXI constants and burst-size helper
// Contents:
//   state_t          : request FSM state encoding
//   AXI_BURST_INCR   : AXI burst type INCR
//   AXI_RESP_OKAY    : AXI OKAY response code
//   axi_burst_size() : AXI size code for a full-width beat of a given lane count
package axi_mem_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_DATA,
    WR_RESP,
    WR_DONE,
    RD_ADDR,
    RD_DATA
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // log2 of the byte-lane count; lane counts are powers of two up to 128.
  function automatic logic [2:0] axi_burst_size(input int strb_width);
    logic [2:0] size;
    size = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if ((1 << i) == strb_width) size = 3'(i);
    end
    return size;
  endfunction

endpackage

// File: rtl/axi_mem_master_timeout.sv
// rtl/axi_mem_master_timeout.sv - response watchdog counter with sticky flag
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   active     : a response is being waited for (counter runs)
//   restart    : a B or R handshake happened this cycle (counter clears)
//   timeout    : sticky, set once TIMEOUT_CYCLES waiting cycles elapse without a handshake
module axi_mem_master_timeout #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic restart,
  output logic timeout
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      if (!active || restart) begin
        cnt <= '0;
      end else if (cnt != LIMIT) begin
        cnt <= cnt + 1'b1;
      end
      // cnt == LIMIT means this is the TIMEOUT_CYCLES-th cycle spent waiting
      if (active && !restart && cnt == LIMIT && !timeout) begin
        timeout <= 1'b1;
`ifndef SYNTHESIS
        $error("axi_mem_master: no AXI response within %0d cycles", TIMEOUT_CYCLES);
`endif
      end
    end
  end

endmodule

// File: rtl/axi_mem_master.sv
// rtl/axi_mem_master.sv - single-outstanding AXI4 INCR-burst master behind a req/wd/rsp stream interface
// Optional feature macro: AXI_MEM_MASTER_TIMEOUT_EN (builds the response watchdog; otherwise timeout is 0).
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   req_valid/ready/we/addr/len: request (len = beats - 1)
//   wd_valid/ready/data/strb   : write-data stream, passed straight to the W channel
//   rsp_valid/ready/we/data/last/err : read data beats or one write completion
//   timeout                    : sticky response-timeout flag
//   m_axi_aw*/w*/b*/ar*/r*     : AXI4 master
module axi_mem_master
  import axi_mem_master_pkg::*;
#(
  parameter int C_AXI_ADDR_WIDTH = 12,
  parameter int C_AXI_DATA_WIDTH = 128,
  parameter int STRB_WIDTH       = C_AXI_DATA_WIDTH / 8,
  parameter int ID_WIDTH         = 1,
  parameter int AXI_ID           = 0,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_we,
  input  logic [C_AXI_ADDR_WIDTH-1:0] req_addr,
  input  logic [7:0]                  req_len,
  input  logic                        wd_valid,
  output logic                        wd_ready,
  input  logic [C_AXI_DATA_WIDTH-1:0] wd_data,
  input  logic [STRB_WIDTH-1:0]       wd_strb,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic                        rsp_we,
  output logic [C_AXI_DATA_WIDTH-1:0] rsp_data,
  output logic                        rsp_last,
  output logic                        rsp_err,
  output logic                        timeout,
  output logic [ID_WIDTH-1:0]         m_axi_awid,
  output logic [C_AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]                  m_axi_awlen,
  output logic [2:0]                  m_axi_awsize,
  output logic [1:0]                  m_axi_awburst,
  output logic                        m_axi_awlock,
  output logic [3:0]                  m_axi_awcache,
  output logic [2:0]                  m_axi_awprot,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  output logic [C_AXI_DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0]       m_axi_wstrb,
  output logic                        m_axi_wlast,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  input  logic [ID_WIDTH-1:0]         m_axi_bid,
  input  logic [1:0]                  m_axi_bresp,
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready,
  output logic [ID_WIDTH-1:0]         m_axi_arid,
  output logic [C_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                  m_axi_arlen,
  output logic [2:0]                  m_axi_arsize,
  output logic [1:0]                  m_axi_arburst,
  output logic                        m_axi_arlock,
  output logic [3:0]                  m_axi_arcache,
  output logic [2:0]                  m_axi_arprot,
  output logic                        m_axi_arvalid,
  input  logic                        m_axi_arready,
  input  logic [ID_WIDTH-1:0]         m_axi_rid,
  input  logic [C_AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                  m_axi_rresp,
  input  logic                        m_axi_rlast,
  input  logic                        m_axi_rvalid,
  output logic                        m_axi_rready
);

  localparam logic [2:0] AXI_SIZE = axi_burst_size(STRB_WIDTH);
  localparam logic [C_AXI_ADDR_WIDTH-1:0] ADDR_MASK = ~(C_AXI_ADDR_WIDTH'(STRB_WIDTH - 1));

  state_t                      state_q, state_d;
  logic                        rdy_q;
  logic [C_AXI_ADDR_WIDTH-1:0] addr_q;
  logic [7:0]                  len_q;
  logic [7:0]                  beat_q;
  logic                        aw_done_q, w_done_q;
  logic                        awvalid_q, arvalid_q;
  logic [1:0]                  bresp_q;

  logic req_fire, aw_fire, w_fire, ar_fire, b_fire, r_fire;

  assign req_fire = req_valid && req_ready;
  assign aw_fire  = awvalid_q && m_axi_awready;
  assign w_fire   = m_axi_wvalid && m_axi_wready;
  assign ar_fire  = arvalid_q && m_axi_arready;
  assign b_fire   = m_axi_bvalid && m_axi_bready;
  assign r_fire   = m_axi_rvalid && m_axi_rready;

  // Constant and latched AXI address-channel fields
  assign m_axi_awid    = ID_WIDTH'(AXI_ID);
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = len_q;
  assign m_axi_awsize  = AXI_SIZE;
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'd0;
  assign m_axi_awprot  = 3'd0;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_arid    = ID_WIDTH'(AXI_ID);
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = AXI_SIZE;
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'd0;
  assign m_axi_arprot  = 3'd0;
  assign m_axi_arvalid = arvalid_q;

  assign m_axi_wdata = wd_data;
  assign m_axi_wstrb = wd_strb;
  assign m_axi_wlast = (beat_q == len_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    req_ready    = 1'b0;
    wd_ready     = 1'b0;
    m_axi_wvalid = 1'b0;
    m_axi_bready = 1'b0;
    m_axi_rready = 1'b0;
    rsp_valid    = 1'b0;
    rsp_we       = 1'b0;
    rsp_data     = '0;
    rsp_last     = 1'b0;
    rsp_err      = 1'b0;
    case (state_q)
      IDLE: begin
        // rdy_q holds req_ready low for the first cycle out of reset
        req_ready = rdy_q;
        if (req_valid && rdy_q) state_d = req_we ? WR_DATA : RD_ADDR;
      end
      WR_DATA: begin
        // W is gated once the last beat is taken so no extra beat leaks out
        m_axi_wvalid = wd_valid && !w_done_q;
        wd_ready     = m_axi_wready && !w_done_q;
        if ((aw_done_q || aw_fire) && (w_done_q || (w_fire && m_axi_wlast))) state_d = WR_RESP;
      end
      WR_RESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) state_d = WR_DONE;
      end
      WR_DONE: begin
        rsp_valid = 1'b1;
        rsp_we    = 1'b1;
        rsp_last  = 1'b1;
        rsp_err   = (bresp_q != AXI_RESP_OKAY);
        if (rsp_ready) state_d = IDLE;
      end
      RD_ADDR: begin
        if (ar_fire) state_d = RD_DATA;
      end
      RD_DATA: begin
        rsp_valid    = m_axi_rvalid;
        m_axi_rready = rsp_ready;
        rsp_data     = m_axi_rdata;
        rsp_last     = m_axi_rlast;
        rsp_err      = (m_axi_rresp != AXI_RESP_OKAY);
        if (r_fire && m_axi_rlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q     <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      awvalid_q <= 1'b0;
      arvalid_q <= 1'b0;
      bresp_q   <= AXI_RESP_OKAY;
    end else begin
      rdy_q <= 1'b1;
      if (req_fire) begin
        addr_q    <= req_addr & ADDR_MASK;
        len_q     <= req_len;
        beat_q    <= '0;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
        awvalid_q <= req_we;
        arvalid_q <= !req_we;
      end
      if (aw_fire) begin
        awvalid_q <= 1'b0;
        aw_done_q <= 1'b1;
      end
      if (w_fire) begin
        beat_q <= beat_q + 1'b1;
        if (m_axi_wlast) w_done_q <= 1'b1;
      end
      if (ar_fire) arvalid_q <= 1'b0;
      if (b_fire) bresp_q <= m_axi_bresp;
    end
  end

`ifdef AXI_MEM_MASTER_TIMEOUT_EN
  axi_mem_master_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .active ((state_q == WR_RESP) || (state_q == RD_DATA)),
    .restart(b_fire || r_fire),
    .timeout(timeout)
  );
  logic unused_ok;
  assign unused_ok = ^{m_axi_bid, m_axi_rid};
`else
  assign timeout = 1'b0;
  logic unused_ok;
  assign unused_ok = ^{m_axi_bid, m_axi_rid, TIMEOUT_CYCLES[0]};
`endif

endmodule

// File: tb/tb_axi_mem_master.sv
// tb/tb_axi_mem_master.sv - self-checking bench: AXI slave model plus word-memory reference
module tb_axi_mem_master;

  localparam int AW  = 12;
  localparam int DW  = 128;
  localparam int SW  = 16;
  localparam int TMO = 40;
`ifdef AXI_MEM_MASTER_TIMEOUT_EN
  localparam logic TO_EXP = 1'b1;
`else
  localparam logic TO_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [7:0]    req_len;
  logic          wd_valid, wd_ready;
  logic [DW-1:0] wd_data;
  logic [SW-1:0] wd_strb;
  logic          rsp_valid, rsp_ready, rsp_we, rsp_last, rsp_err, timeout;
  logic [DW-1:0] rsp_data;
  logic [0:0]    m_axi_awid, m_axi_arid, m_axi_bid, m_axi_rid;
  logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
  logic [7:0]    m_axi_awlen, m_axi_arlen;
  logic [2:0]    m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
  logic [1:0]    m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
  logic          m_axi_awlock, m_axi_arlock;
  logic [3:0]    m_axi_awcache, m_axi_arcache;
  logic          m_axi_awvalid, m_axi_awready, m_axi_arvalid, m_axi_arready;
  logic [DW-1:0] m_axi_wdata, m_axi_rdata;
  logic [SW-1:0] m_axi_wstrb;
  logic          m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic          m_axi_bvalid, m_axi_bready;
  logic          m_axi_rlast, m_axi_rvalid, m_axi_rready;

  axi_mem_master #(
    .C_AXI_ADDR_WIDTH(AW), .C_AXI_DATA_WIDTH(DW), .STRB_WIDTH(SW),
    .ID_WIDTH(1), .AXI_ID(0), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
    .rsp_data(rsp_data), .rsp_last(rsp_last), .rsp_err(rsp_err), .timeout(timeout),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] merge(input logic [127:0] o, input logic [127:0] n,
                                         input logic [15:0] s);
    logic [127:0] r;
    r = o;
    for (int b = 0; b < 16; b++) if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  // reference model (what memory must hold) and slave-side storage
  logic [127:0] ref_mem [256];
  logic [127:0] smem    [256];
  logic [127:0] tx_data [16];
  logic [15:0]  tx_strb [16];

  logic         s_aw_have, b_pending, b_issued, rd_active;
  int           s_wcnt, bwait, rd_beat;
  logic [7:0]   s_aw_idx, rd_idx, rd_len;
  logic [127:0] s_wbuf [16];
  logic [15:0]  s_wsb  [16];
  logic         aw_f, w_f, b_f, ar_f, r_f, rsp_f, req_f;

  // One request end to end: requester, slave and checks, one clock per loop pass.
  // Inputs change at negedge; handshakes are evaluated #1 later and take effect at the next posedge.
  task automatic run_txn(input logic we, input logic [11:0] addr, input logic [7:0] len,
                         input int gap, input int rm, input logic [1:0] bcode, input int bdelay);
    logic [11:0] base;
    logic [7:0]  idx;
    logic        req_done, done, b_seen, prev_req, prev_b;
    int          wsent, wgap, nrsp, cyc;
    base = addr & 12'hFF0;
    idx = addr[11:4];
    req_done = 0; done = 0; b_seen = 0; prev_req = 0; prev_b = 0;
    wsent = 0; wgap = 0; nrsp = 0; cyc = 0;
    s_aw_have = 0; s_wcnt = 0; b_pending = 0; b_issued = 0;
    if (we && bcode == 2'b00)
      for (int i = 0; i <= int'(len); i++)
        ref_mem[int'(idx) + i] = merge(ref_mem[int'(idx) + i], tx_data[i], tx_strb[i]);
    while (!done && cyc < 2000) begin
      @(negedge clk);
      if (w_f) wd_valid = 0;
      if (b_f) m_axi_bvalid = 0;
      if (r_f) m_axi_rvalid = 0;
      req_valid = !req_done;
      req_we = we; req_addr = addr; req_len = len;
      if (we && req_done && !wd_valid && wsent <= int'(len)) begin
        if (wgap > 0) wgap--;
        else begin
          wd_valid = 1; wd_data = tx_data[wsent]; wd_strb = tx_strb[wsent];
        end
      end
      if (rm == 0) rsp_ready = 1;
      else if (rm == 1) rsp_ready = (cyc % 2 == 0);
      else rsp_ready = 1'($urandom_range(0, 1));
      m_axi_awready = 1'($urandom_range(0, 1));
      m_axi_wready  = 1'($urandom_range(0, 1));
      m_axi_arready = 1'($urandom_range(0, 1));
      if (b_pending && !m_axi_bvalid) begin
        if (bwait > 0) bwait--;
        else begin m_axi_bvalid = 1; m_axi_bresp = bcode; end
      end
      if (rd_active && !m_axi_rvalid && $urandom_range(0, 3) != 0) begin
        m_axi_rvalid = 1;
        m_axi_rdata = smem[int'(rd_idx) + rd_beat];
        m_axi_rlast = (rd_beat == int'(rd_len));
        m_axi_rresp = 2'b00;
      end
      #1;
      req_f = req_valid && req_ready;
      aw_f  = m_axi_awvalid && m_axi_awready;
      w_f   = m_axi_wvalid && m_axi_wready;
      b_f   = m_axi_bvalid && m_axi_bready;
      ar_f  = m_axi_arvalid && m_axi_arready;
      r_f   = m_axi_rvalid && m_axi_rready;
      rsp_f = rsp_valid && rsp_ready;
      if (prev_req) begin
        chk("addr_valid_after_req", we ? m_axi_awvalid : m_axi_arvalid, 1);
        chk("req_ready_busy", req_ready, 0);
      end
      if (prev_b) chk("rsp_after_b", rsp_valid, 1);
      if (req_f) req_done = 1;
      if (aw_f) begin
        chk("awaddr", m_axi_awaddr, base);
        chk("awlen", m_axi_awlen, len);
        chk("awsize", m_axi_awsize, 3'd4);
        chk("awburst", m_axi_awburst, 2'b01);
        s_aw_have = 1; s_aw_idx = m_axi_awaddr[11:4];
      end
      if (w_f) begin
        chk("wlast", m_axi_wlast, s_wcnt == int'(len));
        chk("wdata", m_axi_wdata, tx_data[s_wcnt]);
        s_wbuf[s_wcnt] = m_axi_wdata; s_wsb[s_wcnt] = m_axi_wstrb;
        s_wcnt++; wsent++; wgap = gap;
      end
      if (b_f) begin b_pending = 0; b_seen = 1; end
      if (s_aw_have && s_wcnt == int'(len) + 1 && !b_issued) begin
        b_issued = 1; b_pending = 1; bwait = bdelay;
        if (bcode == 2'b00)
          for (int i = 0; i < s_wcnt; i++)
            smem[int'(s_aw_idx) + i] = merge(smem[int'(s_aw_idx) + i], s_wbuf[i], s_wsb[i]);
      end
      if (ar_f) begin
        chk("araddr", m_axi_araddr, base);
        chk("arlen", m_axi_arlen, len);
        chk("arsize", m_axi_arsize, 3'd4);
        rd_active = 1; rd_idx = m_axi_araddr[11:4]; rd_len = m_axi_arlen; rd_beat = 0;
      end
      if (r_f) begin
        if (m_axi_rlast) rd_active = 0;
        rd_beat++;
      end
      if (rsp_f) begin
        if (we) begin
          chk("wr_rsp_we", rsp_we, 1);
          chk("wr_rsp_last", rsp_last, 1);
          chk("wr_rsp_err", rsp_err, bcode != 2'b00);
          chk("wr_rsp_data", rsp_data, 0);
          chk("wr_rsp_after_b", b_seen, 1);
          done = 1;
        end else begin
          chk("rd_rsp_we", rsp_we, 0);
          chk("rd_data", rsp_data, ref_mem[int'(idx) + nrsp]);
          chk("rd_last", rsp_last, nrsp == int'(len));
          chk("rd_err", rsp_err, 0);
          nrsp++;
          if (rsp_last) begin
            chk("rd_beat_count", nrsp, int'(len) + 1);
            done = 1;
          end
        end
      end
      prev_req = req_f;
      prev_b = b_f;
      cyc++;
    end
    chk("txn_completed", done, 1);
  endtask

  initial begin
    logic [7:0] ridx, rlen;
    logic       rwe;
    req_valid = 0; req_we = 0; req_addr = '0; req_len = '0;
    wd_valid = 0; wd_data = '0; wd_strb = '0; rsp_ready = 0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
    m_axi_bid = '0; m_axi_bresp = '0; m_axi_bvalid = 0;
    m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rlast = 0; m_axi_rvalid = 0;
    aw_f = 0; w_f = 0; b_f = 0; ar_f = 0; r_f = 0; rsp_f = 0; req_f = 0;
    rd_active = 0; rd_idx = '0; rd_len = '0; rd_beat = 0; s_aw_idx = '0;
    for (int i = 0; i < 256; i++) begin ref_mem[i] = '0; smem[i] = '0; end

    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_awvalid", m_axi_awvalid, 0);
    chk("rst_arvalid", m_axi_arvalid, 0);
    chk("rst_wvalid", m_axi_wvalid, 0);
    chk("rst_bready", m_axi_bready, 0);
    chk("rst_rready", m_axi_rready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_timeout", timeout, 0);
    rst_n = 1;
    @(negedge clk);
    chk("req_ready_after_rst", req_ready, 1);

    // single-beat write then read-back
    tx_data[0] = 128'h01234567_89ABCDEF_00000000_DEADBEEF;
    tx_strb[0] = 16'hFFFF;
    run_txn(1, 12'h040, 8'd0, 0, 0, 2'b00, 0);
    run_txn(0, 12'h040, 8'd0, 0, 0, 2'b00, 0);

    // 4-beat burst; read back with rsp_ready toggling
    for (int i = 0; i < 4; i++) begin tx_data[i] = 128'(i + 1); tx_strb[i] = 16'hFFFF; end
    run_txn(1, 12'h100, 8'd3, 0, 0, 2'b00, 0);
    run_txn(0, 12'h100, 8'd3, 0, 1, 2'b00, 0);

    // write data with 3-cycle gaps
    for (int i = 0; i < 4; i++) begin tx_data[i] = 128'(32'hA0 + i); tx_strb[i] = 16'h0FF0; end
    run_txn(1, 12'h200, 8'd3, 3, 0, 2'b00, 0);
    run_txn(0, 12'h200, 8'd3, 0, 2, 2'b00, 0);

    // unaligned address
    tx_data[0] = 128'hCAFE_F00D; tx_strb[0] = 16'hFFFF;
    run_txn(1, 12'h10F, 8'd0, 0, 0, 2'b00, 0);
    run_txn(0, 12'h10F, 8'd0, 0, 0, 2'b00, 0);

    // error write response, then a normal request
    tx_data[0] = 128'h5555; tx_strb[0] = 16'hFFFF;
    run_txn(1, 12'h300, 8'd0, 0, 0, 2'b10, 0);
    run_txn(0, 12'h300, 8'd0, 0, 0, 2'b00, 0);

    // withheld write response
    chk("timeout_before", timeout, 0);
    tx_data[0] = 128'h7777; tx_strb[0] = 16'hFFFF;
    run_txn(1, 12'h380, 8'd0, 0, 0, 2'b00, TMO + 5);
    chk("timeout_after_b", timeout, TO_EXP);
    run_txn(0, 12'h380, 8'd0, 0, 0, 2'b00, 0);
    chk("timeout_sticky", timeout, TO_EXP);

    // randomized traffic against the reference memory
    for (int t = 0; t < 30; t++) begin
      rlen = 8'($urandom_range(0, 15));
      ridx = 8'($urandom_range(0, 255 - int'(rlen)));
      rwe = 1'($urandom_range(0, 1));
      for (int i = 0; i < 16; i++) begin
        tx_data[i] = {$urandom, $urandom, $urandom, $urandom};
        tx_strb[i] = 16'($urandom);
      end
      run_txn(rwe, {ridx, 4'($urandom_range(0, 15))}, rlen, $urandom_range(0, 2),
              $urandom_range(0, 2), ($urandom_range(0, 5) == 0) ? 2'b10 : 2'b00,
              $urandom_range(0, 3));
      run_txn(0, {ridx, 4'h0}, rlen, 0, $urandom_range(0, 2), 2'b00, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
